// File: rtl/csr_io_arbiter.sv
// Two-master arbiter for the CSR i/o port: J1 core (master 0) and UART debug/loader (master 1).
// Each request becomes exactly one io_rd/io_wr strobe cycle followed by a one-cycle ack.
module csr_io_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int LOCK_MAX      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        io_wr,
    output logic        io_rd,
    output logic [15:0] io_addr,
    output logic [15:0] io_dout,
    input  logic [15:0] io_din,
    output logic        gnt_id,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t      state;
    logic        last_grant;
    logic        owned;
    logic [7:0]  lock_cnt;
    logic        lat_we;
    logic        lat_lock;

    logic        owner_lock;
    logic        hold;
    logic        elig0;
    logic        elig1;
    logic        grant_valid;
    logic        grant_sel;
    logic        sel_we;
    logic        sel_lock;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [7:0]  next_cnt;

    // The owner is always the last granted master, so gnt_id doubles as the owner index.
    always_comb begin
        owner_lock = gnt_id ? m1_lock : m0_lock;
        hold       = owned && owner_lock;
        elig0      = m0_req && !(hold && gnt_id);
        elig1      = m1_req && !(hold && !gnt_id);
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            grant_sel = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
        end else begin
            grant_sel = elig1;
        end
        sel_we    = grant_sel ? m1_we    : m0_we;
        sel_lock  = grant_sel ? m1_lock  : m0_lock;
        sel_addr  = grant_sel ? m1_addr  : m0_addr;
        sel_wdata = grant_sel ? m1_wdata : m0_wdata;
        next_cnt  = lock_cnt + 8'd1;
    end

    // io_addr/io_dout are loaded on the grant edge, so they are stable for the whole ACCESS
    // cycle and simply hold their values afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owned      <= 1'b0;
            lock_cnt   <= 8'd0;
            lat_we     <= 1'b0;
            lat_lock   <= 1'b0;
            gnt_id     <= 1'b0;
            busy       <= 1'b0;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
            io_addr    <= 16'd0;
            io_dout    <= 16'd0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= 16'd0;
            m1_rdata   <= 16'd0;
        end else begin
            io_rd  <= 1'b0;
            io_wr  <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (owned && !owner_lock) begin
                        owned    <= 1'b0;
                        lock_cnt <= 8'd0;
                    end
                    if (grant_valid) begin
                        gnt_id   <= grant_sel;
                        lat_we   <= sel_we;
                        lat_lock <= sel_lock;
                        io_addr  <= sel_addr;
                        io_dout  <= sel_wdata;
                        io_wr    <= sel_we;
                        io_rd    <= !sel_we;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (gnt_id) begin
                            m1_rdata <= io_din;
                        end else begin
                            m0_rdata <= io_din;
                        end
                    end
                    if (gnt_id) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    busy       <= 1'b0;
                    last_grant <= gnt_id;
                    // Reaching LOCK_MAX releases ownership; last_grant then hands the tie to the other master.
                    if (lat_lock && (next_cnt != LOCK_LIMIT)) begin
                        owned    <= 1'b1;
                        lock_cnt <= next_cnt;
                    end else begin
                        owned    <= 1'b0;
                        lock_cnt <= 8'd0;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_io_arbiter.sv
// Bench for csr_io_arbiter: a round-robin and a fixed-priority instance share the master
// inputs; a transaction-level model predicts every grant, strobe, ack and read value.
module tb_csr_io_arbiter;
    localparam int LMAX = 4;

    logic clk;
    logic rst;
    logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic rr_ack0, rr_ack1, rr_wr, rr_rd, rr_gnt, rr_busy;
    logic [15:0] rr_rdata0, rr_rdata1, rr_addr, rr_dout, rr_din;
    logic fp_ack0, fp_ack1, fp_wr, fp_rd, fp_gnt, fp_busy;
    logic [15:0] fp_rdata0, fp_rdata1, fp_addr, fp_dout, fp_din;

    logic        sel;
    logic        din_fixed_en;
    logic [15:0] din_fixed;

    // CSR read data: either a fixed value or an address-derived pattern.
    assign rr_din = din_fixed_en ? din_fixed : (rr_addr ^ 16'h5A5A);
    assign fp_din = din_fixed_en ? din_fixed : (fp_addr ^ 16'h5A5A);

    csr_io_arbiter #(.PRIORITY_MODE(0), .LOCK_MAX(LMAX)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(rr_ack0), .m0_rdata(rr_rdata0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(rr_ack1), .m1_rdata(rr_rdata1),
        .io_wr(rr_wr), .io_rd(rr_rd), .io_addr(rr_addr), .io_dout(rr_dout), .io_din(rr_din),
        .gnt_id(rr_gnt), .busy(rr_busy)
    );

    csr_io_arbiter #(.PRIORITY_MODE(1), .LOCK_MAX(LMAX)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_ack0), .m0_rdata(fp_rdata0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_ack1), .m1_rdata(fp_rdata1),
        .io_wr(fp_wr), .io_rd(fp_rd), .io_addr(fp_addr), .io_dout(fp_dout), .io_din(fp_din),
        .gnt_id(fp_gnt), .busy(fp_busy)
    );

    logic o_rd, o_wr, o_ack0, o_ack1, o_gnt, o_busy;
    logic [15:0] o_addr, o_dout, o_rdata0, o_rdata1;

    always_comb begin
        if (sel) begin
            o_rd = fp_rd; o_wr = fp_wr; o_ack0 = fp_ack0; o_ack1 = fp_ack1; o_gnt = fp_gnt;
            o_busy = fp_busy; o_addr = fp_addr; o_dout = fp_dout; o_rdata0 = fp_rdata0; o_rdata1 = fp_rdata1;
        end else begin
            o_rd = rr_rd; o_wr = rr_wr; o_ack0 = rr_ack0; o_ack1 = rr_ack1; o_gnt = rr_gnt;
            o_busy = rr_busy; o_addr = rr_addr; o_dout = rr_dout; o_rdata0 = rr_rdata0; o_rdata1 = rr_rdata1;
        end
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard and model state ----------------
    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_ack = 0;
    int ack_log[$];
    logic [33:0] exp_q[$];          // {master, we, addr, data}, waiting for its ack
    logic [15:0] exp_rdata[2];
    logic [15:0] exp_addr;
    logic        exp_gnt;
    bit          s_valid;
    logic [33:0] s_txn;
    bit          m_last, m_owned, m_owner;
    int          m_cnt, m_wait;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_din(input logic [15:0] a);
        return din_fixed_en ? din_fixed : (a ^ 16'h5A5A);
    endfunction

    function automatic void model_reset();
        m_last = 1'b1; m_owned = 1'b0; m_owner = 1'b0; m_cnt = 0; m_wait = 0;
        s_valid = 1'b0; exp_q.delete();
        exp_rdata[0] = 16'd0; exp_rdata[1] = 16'd0; exp_addr = 16'd0; exp_gnt = 1'b0;
    endfunction

    // Transaction-level arbitration: decides who (if anyone) is granted at the coming edge.
    function automatic void model_step();
        bit e0, e1, w, lk;
        s_valid = 1'b0;
        if (m_wait > 0) begin
            m_wait--;
            return;
        end
        e0 = m0_req; e1 = m1_req;
        if (m_owned) begin
            if (m_owner ? m1_lock : m0_lock) begin
                if (m_owner) e0 = 1'b0; else e1 = 1'b0;
            end else begin
                m_owned = 1'b0; m_cnt = 0;
            end
        end
        if (!(e0 || e1)) return;
        if (e0 && e1) w = sel ? 1'b0 : !m_last;
        else          w = e1;
        s_valid = 1'b1;
        s_txn = w ? {1'b1, m1_we, m1_addr, m1_wdata} : {1'b0, m0_we, m0_addr, m0_wdata};
        lk = w ? m1_lock : m0_lock;
        m_wait = 2;
        m_last = w;
        if (lk) begin
            m_cnt++;
            if (m_cnt == LMAX) begin m_owned = 1'b0; m_cnt = 0; end
            else begin m_owned = 1'b1; m_owner = w; end
        end else begin
            m_owned = 1'b0; m_cnt = 0;
        end
    endfunction

    task automatic check();
        logic [33:0] t;
        bit [1:0] acks;
        bit ack_exp;
        acks = 2'b00; ack_exp = 1'b0;
        checks++;
        if (o_rd && o_wr) begin
            errors++;
            $display("FAIL strobe_excl: io_rd and io_wr both high at %0t", $time);
        end
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            ack_exp = 1'b1;
            acks[t[33]] = 1'b1;
            if (!t[32]) exp_rdata[t[33]] = exp_din(t[31:16]);
        end
        chk("ack0", 16'(o_ack0), 16'(acks[0]));
        chk("ack1", 16'(o_ack1), 16'(acks[1]));
        chk("rdata0", o_rdata0, exp_rdata[0]);
        chk("rdata1", o_rdata1, exp_rdata[1]);
        if (s_valid) begin
            exp_gnt = s_txn[33]; exp_addr = s_txn[31:16];
            chk("io_rd", 16'(o_rd), 16'(!s_txn[32]));
            chk("io_wr", 16'(o_wr), 16'(s_txn[32]));
            if (s_txn[32]) chk("io_dout", o_dout, s_txn[15:0]);
            exp_q.push_back(s_txn);
        end else begin
            chk("io_rd_idle", 16'(o_rd), 16'd0);
            chk("io_wr_idle", 16'(o_wr), 16'd0);
        end
        chk("gnt_id", 16'(o_gnt), 16'(exp_gnt));
        chk("io_addr", o_addr, exp_addr);
        chk("busy", 16'(o_busy), 16'(s_valid || ack_exp));
        n_strobe += int'(o_rd) + int'(o_wr);
        n_ack += int'(o_ack0) + int'(o_ack1);
        if (o_ack0 || o_ack1) ack_log.push_back(o_ack1 ? 1 : 0);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_m(input int i, input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (i == 0) begin
            m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic do_reset(input logic use_fp);
        sel = use_fp;
        rst = 1'b1;
        set_m(0, 0, 0, 0, 16'd0, 16'd0);
        set_m(1, 0, 0, 0, 16'd0, 16'd0);
        din_fixed_en = 1'b0; din_fixed = 16'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", 16'({o_ack0, o_ack1}), 16'd0);
        chk("rst_strobe", 16'({o_rd, o_wr}), 16'd0);
        chk("rst_gnt_busy", 16'({o_gnt, o_busy}), 16'd0);
        chk("rst_addr", o_addr, 16'd0);
        chk("rst_dout", o_dout, 16'd0);
        chk("rst_rdata", o_rdata0 | o_rdata1, 16'd0);
        model_reset();
        ack_log.delete();
        rst = 1'b0;
    endtask

    task automatic run_acks(input int n, input int budget);
        for (int c = 0; c < budget && ack_log.size() < n; c++) tick();
    endtask

    task automatic check_order(input string name, input int n, input logic [7:0] pat);
        checks++;
        if (ack_log.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d acks expected %0d", name, ack_log.size(), n);
        end else begin
            for (int k = 0; k < n; k++) chk(name, 16'(ack_log[k]), 16'(pat[k]));
        end
    endtask

    task automatic drain();
        set_m(0, 0, 0, 0, m0_addr, m0_wdata);
        set_m(1, 0, 0, 0, m1_addr, m1_wdata);
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic rand_phase(input int n);
        bit act[2];
        int gap[2];
        int started;
        started = 0; act[0] = 0; act[1] = 0; gap[0] = 0; gap[1] = 0;
        n_strobe = 0; n_ack = 0;
        for (int c = 0; c < n * 10 && n_ack < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] && ((i == 0) ? o_ack0 : o_ack1)) begin
                    act[i] = 0;
                    gap[i] = $urandom_range(0, 2);
                    set_m(i, 0, 0, 0, 16'd0, 16'd0);
                end else if (!act[i] && gap[i] > 0) begin
                    gap[i]--;
                end
                if (!act[i] && gap[i] == 0 && started < n) begin
                    act[i] = 1; started++;
                    set_m(i, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
                end
            end
            tick();
        end
        drain();
        checks++;
        if (n_ack < n) begin
            errors++;
            $display("FAIL rand_progress: got %0d acks expected %0d", n_ack, n);
        end
        chk("strobe_vs_ack", 16'(n_strobe), 16'(n_ack));
    endtask

    // ---------------- table-driven single transactions ----------------
    typedef struct {
        logic        m;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{m: 1'b0, we: 1'b0, addr: 16'h1234, wdata: 16'h0000, din: 16'h00A5, exp_rdata: 16'h00A5};
        vecs[1] = '{m: 1'b1, we: 1'b1, addr: 16'h0010, wdata: 16'hBEEF, din: 16'h1111, exp_rdata: 16'h0000};
        vecs[2] = '{m: 1'b1, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, din: 16'h7E01, exp_rdata: 16'h7E01};
        vecs[3] = '{m: 1'b0, we: 1'b1, addr: 16'hFFFF, wdata: 16'h0011, din: 16'h2222, exp_rdata: 16'h00A5};
        vecs[4] = '{m: 1'b0, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, din: 16'hFFFF, exp_rdata: 16'hFFFF};
        vecs[5] = '{m: 1'b1, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, din: 16'h0000, exp_rdata: 16'h0000};

        do_reset(1'b0);
        din_fixed_en = 1'b1;
        foreach (vecs[i]) begin
            din_fixed = vecs[i].din;
            set_m(int'(vecs[i].m), 1'b1, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata);
            tick();
            chk("vec_strobe", 16'({o_wr, o_rd}), vecs[i].we ? 16'd2 : 16'd1);
            chk("vec_addr", o_addr, vecs[i].addr);
            if (vecs[i].we) chk("vec_dout", o_dout, vecs[i].wdata);
            tick();
            chk("vec_ack", 16'(vecs[i].m ? o_ack1 : o_ack0), 16'd1);
            chk("vec_strobe_off", 16'({o_wr, o_rd}), 16'd0);
            chk("vec_rdata", vecs[i].m ? o_rdata1 : o_rdata0, vecs[i].exp_rdata);
            set_m(int'(vecs[i].m), 1'b0, 1'b0, 1'b0, vecs[i].addr, vecs[i].wdata);
            tick();
        end

        // Round-robin contention: both masters write continuously.
        do_reset(1'b0);
        set_m(0, 1, 1, 0, 16'h0100, 16'h0011);
        set_m(1, 1, 1, 0, 16'h0200, 16'h0022);
        run_acks(4, 20);
        check_order("rr_order", 4, 8'b0000_1010);
        drain();

        // Fixed priority: m1 starves until m0 stops requesting.
        do_reset(1'b1);
        set_m(0, 1, 1, 0, 16'h0300, 16'h0033);
        set_m(1, 1, 0, 0, 16'h0400, 16'h0000);
        for (int c = 0; c < 40 && ack_log.size() < 5; c++) begin
            tick();
            if (ack_log.size() == 4) m0_req = 1'b0;
        end
        check_order("fp_order", 5, 8'b0001_0000);
        drain();

        // Lock held for LOCK_MAX transactions, then forced release.
        do_reset(1'b0);
        set_m(1, 1, 0, 1, 16'h0030, 16'h0000);
        tick();
        set_m(0, 1, 1, 0, 16'h0031, 16'h0055);
        run_acks(5, 40);
        check_order("lock_max", 5, 8'b0000_1111);
        drain();

        // Lock dropped after two transactions.
        do_reset(1'b0);
        set_m(1, 1, 0, 1, 16'h0030, 16'h0000);
        tick();
        set_m(0, 1, 1, 0, 16'h0031, 16'h0066);
        for (int c = 0; c < 30 && ack_log.size() < 3; c++) begin
            tick();
            if (ack_log.size() == 2) m1_lock = 1'b0;
        end
        check_order("lock_drop", 3, 8'b0000_0011);
        drain();

        // Reset asserted in the ACCESS cycle.
        do_reset(1'b0);
        set_m(0, 1, 0, 0, 16'h0040, 16'h0000);
        tick();
        chk("pre_rst_rd", 16'(o_rd), 16'd1);
        rst = 1'b1;
        #1;
        chk("midrst_strobe", 16'({o_rd, o_wr}), 16'd0);
        chk("midrst_ack_busy", 16'({o_ack0, o_ack1, o_busy, o_gnt}), 16'd0);
        chk("midrst_addr", o_addr, 16'd0);
        model_reset();
        @(negedge clk);
        chk("midrst_no_ack", 16'({o_ack0, o_ack1}), 16'd0);
        rst = 1'b0;
        ack_log.delete();
        set_m(1, 1, 0, 0, 16'h0050, 16'h0000);
        run_acks(1, 10);
        check_order("post_rst_tie", 1, 8'b0000_0000);
        drain();

        // Random mixed traffic on both arbitration modes.
        do_reset(1'b0);
        rand_phase(100);
        do_reset(1'b1);
        rand_phase(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
